fp32_norm_round_pack: RTL and testbench
=======================================

Name: fp32_norm_round_pack

Overview:
Multi-cycle back end of the FP32 datapath, and the inverse of the operand decomposition stage. It takes sign, biased exponent and the raw mantissa sum of the add/sub stage. It normalizes iteratively, applies IEEE-754 rounding per rmode, and packs a 32-bit result. Valid/ready handshake on both sides; one operation in flight.

Parameters:
MAX_LSH, 26, maximum left-shift iterations before forced exit (exceeding it is a design error, asserted in sim)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  operand bundle valid
in_ready  output  1  block can accept (high only in IDLE)
in_s  input  1  result sign
in_e  input  8  biased exponent of larger operand
in_m  input  28  [27] carry, [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky
rmode  input  2  00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf; sampled at accept
out_valid  output  1  Y/flags valid
out_ready  input  1  consumer accepts
Y  output  32  packed FP32 result
overflow  output  1  result exponent reached 255
inexact  output  1  any of G/R/S nonzero after final alignment

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, Y=0, overflow=0, inexact=0; any in-flight operation is discarded.
- Internal exponent is 10-bit signed; mantissa register is 28 bits; the sticky bit ORs every bit shifted out.
- IDLE: in_valid&in_ready loads s, e, m, rmode -> NORM. in_ready=0 in all other states.
- NORM, one decision per cycle, in priority order:
  - m[27]=1: shift right 1, sticky|=m[0], e+=1 -> ROUND.
  - m==0: -> ROUND with zero flag set.
  - m[26]=1: -> ROUND.
  - e<=1: subnormal. Set e=0 (exponent field 0, no further shift) -> ROUND.
  - Otherwise: shift left 1, e-=1, stay in NORM.
- ROUND: inc = RNE: G&(R|S|LSB); RTZ: 0; +inf: ~s&(G|R|S); -inf: s&(G|R|S).
  - Fraction+hidden+inc carries to 2^24: shift right, e+=1.
  - inexact=G|R|S.
  - Subnormal that rounds up to hidden=1: e becomes 1.
  - Then -> DONE.
- Overflow (e>=255 after rounding): overflow=1.
  - Y=Inf for RNE, for +inf when s=0, and for -inf when s=1.
  - Otherwise Y=max finite (7F7FFFFF with sign).
- Zero result: Y={rmode==11,31'b0}, inexact=0.
- DONE: out_valid=1; Y and flags held stable until out_ready. On handshake -> IDLE, out_valid=0 on the next cycle.
- Latency, accept to out_valid: 3 cycles plus the number of NORM left shifts. Carry case is 3. Throughput: one operation per (latency+1) cycles at minimum.
- in_valid during a busy state is ignored; the upstream holds it.
- out_ready high before DONE has no effect.

Optional Feature:
FP32_NORM_FAST_EN
- Defined: NORM shifts left by min(lz4, e-1) per cycle. lz4 is the leading-zero count of m[26:23], capped at 4.
  - A cycle where m[26:23]==0 and e>4 shifts 4.
  - Leading-zero latency becomes ceil(n/4).
- Undefined: 1 bit per cycle as above.
- Results are bit-identical either way; only latency differs.

Decomposition:
- Package fp32_pkg holds:
  - rmode constants RM_RNE/RM_RTZ/RM_RUP/RM_RDN
  - BIAS=127, EXP_MAX=255, widths (MANT_W=23, MW_RAW=28)
  - state enum IDLE/NORM/ROUND/DONE
  - constants POS_INF/MAX_FIN
- One sub-module, fp32_round_inc: combinational. Takes rmode, s, lsb, g, r, st and produces the inc bit. It is shared with future multiplier rounding.

Test Plan:
- in_s=0, in_e=127, in_m=28'h4000000, RNE -> Y=3F800000 at accept+3, inexact=0.
- in_e=127, in_m=28'h8000000 (carry) -> Y=40000000 at accept+3.
- in_e=130, in_m=28'h0800000 -> 3 NORM shifts, Y=3F800000 at accept+6. With FP32_NORM_FAST_EN, at accept+4.
- Rounding tie, in_e=127, in_m=28'h7FFFFFC:
  - RNE -> Y=40000000, inexact=1.
  - RTZ -> Y=3FFFFFFF.
  - rmode=11 with in_s=1 -> Y=C0000000.
- Overflow, in_e=254, in_m=28'h8000000:
  - RNE -> Y=7F800000, overflow=1.
  - RTZ -> Y=7F7FFFFF, overflow=1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE -> Y stable, in_ready=0.
  - Assert rst mid-NORM -> out_valid=0 and in_ready=1 immediately.
  - Zero mantissa with rmode=11 -> Y=80000000.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared FP32 datapath constants, rounding-mode encodings and the back-end state enum.
package fp32_pkg;

  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam int MANT_W  = 23;
  localparam int MW_RAW  = 28;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] MAX_FIN = 32'h7F7F_FFFF;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_e;

  // Leading-zero count of a nibble, saturating at 4.
  function automatic logic [2:0] lz4(input logic [3:0] n);
    casez (n)
      4'b1???: return 3'd0;
      4'b01??: return 3'd1;
      4'b001?: return 3'd2;
      4'b0001: return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/fp32_round_inc.sv
// IEEE-754 round-increment decision from rounding mode, sign, LSB and guard/round/sticky.
module fp32_round_inc
  import fp32_pkg::*;
(
  input  logic [1:0] rmode_i,
  input  logic       s_i,
  input  logic       lsb_i,
  input  logic       g_i,
  input  logic       r_i,
  input  logic       st_i,
  output logic       inc_o
);

  logic any_lost;

  assign any_lost = g_i | r_i | st_i;

  always_comb begin
    inc_o = 1'b0;
    case (rmode_i)
      RM_RNE:  inc_o = g_i & (r_i | st_i | lsb_i);
      RM_RTZ:  inc_o = 1'b0;
      RM_RUP:  inc_o = ~s_i & any_lost;
      RM_RDN:  inc_o = s_i & any_lost;
      default: inc_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fp32_norm_round_pack.sv
// FP32 back end: iterative normalize, round, pack. Define FP32_NORM_FAST_EN to
// normalize up to 4 bit positions per cycle instead of 1 (results identical).
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand bundle
// NORM  | one normalize decision per cycle (right carry shift, left shifts, subnormal clamp)
// ROUND | compute increment, carry-out, overflow/zero handling, register Y and flags
// DONE  | out_valid high, Y/flags held until out_ready
module fp32_norm_round_pack
  import fp32_pkg::*;
#(
  parameter int MAX_LSH = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_s,
  input  logic [7:0]        in_e,
  input  logic [MW_RAW-1:0] in_m,
  input  logic [1:0]        rmode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       Y,
  output logic              overflow,
  output logic              inexact
);

  state_e             state_q;
  logic               s_q;
  logic signed [9:0]  e_q;
  logic [MW_RAW-1:0]  m_q;
  logic [1:0]         rm_q;
  logic               zero_q;
  logic [5:0]         lsh_cnt_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [31:0]        y_q;
  logic               ovf_q;
  logic               inx_q;

  logic               need_lsh;
  logic [2:0]         sh;
  logic               inc;
  logic [24:0]        sum;
  logic signed [9:0]  e_r;
  logic [MANT_W-1:0]  frac;
  logic               to_inf;
  logic [31:0]        y_d;
  logic               ovf_d;
  logic               inx_d;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Y         = y_q;
  assign overflow  = ovf_q;
  assign inexact   = inx_q;

  assign need_lsh = ~m_q[27] & (m_q != '0) & ~m_q[26] & (e_q > 10'sd1);

`ifdef FP32_NORM_FAST_EN
  // Never shift past exponent 1; the remainder is expressed as a subnormal.
  always_comb begin
    sh = lz4(m_q[26:23]);
    if (e_q <= $signed({7'd0, sh}))
      sh = 3'(e_q - 10'sd1);
  end
`else
  assign sh = 3'd1;
`endif

  fp32_round_inc u_round_inc (
    .rmode_i (rm_q),
    .s_i     (s_q),
    .lsb_i   (m_q[3]),
    .g_i     (m_q[2]),
    .r_i     (m_q[1]),
    .st_i    (m_q[0]),
    .inc_o   (inc)
  );

  always_comb begin
    sum    = {1'b0, m_q[26:3]} + {24'd0, inc};
    e_r    = e_q;
    frac   = sum[MANT_W-1:0];
    if (sum[24]) begin
      frac = sum[23:1];
      e_r  = e_q + 10'sd1;
    end else if (e_q == 10'sd0 && sum[23]) begin
      e_r  = 10'sd1;
    end
    to_inf = (rm_q == RM_RNE) | ((rm_q == RM_RUP) & ~s_q) | ((rm_q == RM_RDN) & s_q);
    ovf_d  = 1'b0;
    inx_d  = |m_q[2:0];
    if (zero_q) begin
      y_d   = {rm_q == RM_RDN, 31'd0};
      inx_d = 1'b0;
    end else if (e_r >= $signed(10'(EXP_MAX))) begin
      ovf_d = 1'b1;
      y_d   = (to_inf ? POS_INF : MAX_FIN) | {s_q, 31'd0};
    end else begin
      y_d   = {s_q, e_r[7:0], frac};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= 1'b0;
      e_q         <= '0;
      m_q         <= '0;
      rm_q        <= RM_RNE;
      zero_q      <= 1'b0;
      lsh_cnt_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
      inx_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            s_q        <= in_s;
            e_q        <= {2'b00, in_e};
            m_q        <= in_m;
            rm_q       <= rmode;
            zero_q     <= 1'b0;
            lsh_cnt_q  <= '0;
            in_ready_q <= 1'b0;
            state_q    <= NORM;
          end
        end
        NORM: begin
          if (m_q[27]) begin
            m_q     <= {1'b0, m_q[27:2], m_q[1] | m_q[0]};
            e_q     <= e_q + 10'sd1;
            state_q <= ROUND;
          end else if (m_q == '0) begin
            zero_q  <= 1'b1;
            state_q <= ROUND;
          end else if (m_q[26]) begin
            state_q <= ROUND;
          end else if (e_q <= 10'sd1) begin
            e_q     <= 10'sd0;
            state_q <= ROUND;
          end else if (lsh_cnt_q >= 6'(MAX_LSH)) begin
            state_q <= ROUND;
          end else begin
            m_q       <= m_q << sh;
            e_q       <= e_q - $signed({7'd0, sh});
            lsh_cnt_q <= lsh_cnt_q + 6'd1;
          end
        end
        ROUND: begin
          y_q         <= y_d;
          ovf_q       <= ovf_d;
          inx_q       <= inx_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  a_lsh_bound: assert property (@(posedge clk) disable iff (rst)
    !(state_q == NORM && need_lsh && lsh_cnt_q >= 6'(MAX_LSH)));

endmodule

// File: tb/tb_fp32_norm_round_pack.sv
// Directed-vector bench for fp32_norm_round_pack; latencies adapt to FP32_NORM_FAST_EN.
module tb_fp32_norm_round_pack;

`ifdef FP32_NORM_FAST_EN
  localparam int LAT_SH3  = 4;
  localparam int LAT_SUB2 = 4;
`else
  localparam int LAT_SH3  = 6;
  localparam int LAT_SUB2 = 5;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_s;
  logic [7:0]  in_e;
  logic [27:0] in_m;
  logic [1:0]  rmode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Y;
  logic        overflow;
  logic        inexact;

  int total = 0;
  int bad   = 0;

  fp32_norm_round_pack #(.MAX_LSH(26)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s      (in_s),
    .in_e      (in_e),
    .in_m      (in_m),
    .rmode     (rmode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .overflow  (overflow),
    .inexact   (inexact)
  );

  always #5 clk = ~clk;

  // Launch one operation, wait (bounded) for out_valid, capture, then complete the handshake.
  task automatic do_op(input logic s, input logic [7:0] e, input logic [27:0] m,
                       input logic [1:0] rm, output logic [31:0] y, output logic ovf,
                       output logic inx, output int lat);
    @(negedge clk);
    in_s = s; in_e = e; in_m = m; rmode = rm; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    y = Y; ovf = overflow; inx = inexact;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (Y !== 32'h0) begin bad++; $display("FAIL reset_y got=%h exp=00000000", Y); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    total++; if (inexact !== 1'b0) begin bad++; $display("FAIL reset_inexact got=%b exp=0", inexact); end
  endtask

  task automatic test_normalize();
    logic [31:0] y; logic ovf, inx; int lat;
    do_op(1'b0, 8'd127, 28'h4000000, 2'b00, y, ovf, inx, lat);
    total++; if (y !== 32'h3F800000) begin bad++; $display("FAIL hidden_y got=%h exp=3f800000", y); end
    total++; if (lat !== 3) begin bad++; $display("FAIL hidden_lat got=%0d exp=3", lat); end
    total++; if (inx !== 1'b0) begin bad++; $display("FAIL hidden_inexact got=%b exp=0", inx); end
    do_op(1'b0, 8'd127, 28'h8000000, 2'b00, y, ovf, inx, lat);
    total++; if (y !== 32'h40000000) begin bad++; $display("FAIL carry_y got=%h exp=40000000", y); end
    total++; if (lat !== 3) begin bad++; $display("FAIL carry_lat got=%0d exp=3", lat); end
    do_op(1'b0, 8'd130, 28'h0800000, 2'b00, y, ovf, inx, lat);
    total++; if (y !== 32'h3F800000) begin bad++; $display("FAIL lsh3_y got=%h exp=3f800000", y); end
    total++; if (lat !== LAT_SH3) begin bad++; $display("FAIL lsh3_lat got=%0d exp=%0d", lat, LAT_SH3); end
  endtask

  task automatic test_rounding();
    logic [31:0] y; logic ovf, inx; int lat;
    do_op(1'b0, 8'd127, 28'h7FFFFFC, 2'b00, y, ovf, inx, lat);
    total++; if (y !== 32'h40000000) begin bad++; $display("FAIL tie_rne_y got=%h exp=40000000", y); end
    total++; if (inx !== 1'b1) begin bad++; $display("FAIL tie_rne_inexact got=%b exp=1", inx); end
    do_op(1'b0, 8'd127, 28'h7FFFFFC, 2'b01, y, ovf, inx, lat);
    total++; if (y !== 32'h3FFFFFFF) begin bad++; $display("FAIL tie_rtz_y got=%h exp=3fffffff", y); end
    total++; if (inx !== 1'b1) begin bad++; $display("FAIL tie_rtz_inexact got=%b exp=1", inx); end
    do_op(1'b1, 8'd127, 28'h7FFFFFC, 2'b11, y, ovf, inx, lat);
    total++; if (y !== 32'hC0000000) begin bad++; $display("FAIL tie_rdn_neg_y got=%h exp=c0000000", y); end
    do_op(1'b0, 8'd127, 28'h7FFFFFC, 2'b11, y, ovf, inx, lat);
    total++; if (y !== 32'h3FFFFFFF) begin bad++; $display("FAIL tie_rdn_pos_y got=%h exp=3fffffff", y); end
  endtask

  task automatic test_overflow();
    logic [31:0] y; logic ovf, inx; int lat;
    do_op(1'b0, 8'd254, 28'h8000000, 2'b00, y, ovf, inx, lat);
    total++; if (y !== 32'h7F800000) begin bad++; $display("FAIL ovf_rne_y got=%h exp=7f800000", y); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_rne_flag got=%b exp=1", ovf); end
    do_op(1'b0, 8'd254, 28'h8000000, 2'b01, y, ovf, inx, lat);
    total++; if (y !== 32'h7F7FFFFF) begin bad++; $display("FAIL ovf_rtz_y got=%h exp=7f7fffff", y); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_rtz_flag got=%b exp=1", ovf); end
    do_op(1'b1, 8'd254, 28'h8000000, 2'b10, y, ovf, inx, lat);
    total++; if (y !== 32'hFF7FFFFF) begin bad++; $display("FAIL ovf_rup_neg_y got=%h exp=ff7fffff", y); end
    do_op(1'b0, 8'd126, 28'h4000000, 2'b00, y, ovf, inx, lat);
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL no_ovf_flag got=%b exp=0", ovf); end
  endtask

  task automatic test_subnormal_zero();
    logic [31:0] y; logic ovf, inx; int lat;
    do_op(1'b0, 8'd1, 28'h0400000, 2'b00, y, ovf, inx, lat);
    total++; if (y !== 32'h00080000) begin bad++; $display("FAIL sub_clamp_y got=%h exp=00080000", y); end
    do_op(1'b0, 8'd3, 28'h0800000, 2'b00, y, ovf, inx, lat);
    total++; if (y !== 32'h00400000) begin bad++; $display("FAIL sub_shift_y got=%h exp=00400000", y); end
    total++; if (lat !== LAT_SUB2) begin bad++; $display("FAIL sub_shift_lat got=%0d exp=%0d", lat, LAT_SUB2); end
    do_op(1'b0, 8'd1, 28'h3FFFFFC, 2'b00, y, ovf, inx, lat);
    total++; if (y !== 32'h00800000) begin bad++; $display("FAIL sub_roundup_y got=%h exp=00800000", y); end
    total++; if (inx !== 1'b1) begin bad++; $display("FAIL sub_roundup_inexact got=%b exp=1", inx); end
    do_op(1'b0, 8'd100, 28'h0000000, 2'b11, y, ovf, inx, lat);
    total++; if (y !== 32'h80000000) begin bad++; $display("FAIL zero_rdn_y got=%h exp=80000000", y); end
    total++; if (inx !== 1'b0) begin bad++; $display("FAIL zero_rdn_inexact got=%b exp=0", inx); end
    do_op(1'b1, 8'd100, 28'h0000000, 2'b00, y, ovf, inx, lat);
    total++; if (y !== 32'h00000000) begin bad++; $display("FAIL zero_rne_y got=%h exp=00000000", y); end
  endtask

  task automatic test_backpressure();
    logic [31:0] y0; int lat;
    @(negedge clk);
    in_s = 1'b1; in_e = 8'd128; in_m = 28'h6000000; rmode = 2'b00; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_s = 1'b0; in_e = 8'd10; in_m = 28'h8000000;
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    total++; if (lat !== 3) begin bad++; $display("FAIL bp_lat got=%0d exp=3", lat); end
    y0 = Y;
    total++; if (y0 !== 32'hC0400000) begin bad++; $display("FAIL bp_y got=%h exp=c0400000", y0); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (Y !== 32'hC0400000 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d y=%h ov=%b ir=%b exp=c0400000/1/0", i, Y, out_valid, in_ready);
      end
    end
    @(negedge clk); out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release ov=%b ir=%b exp=0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_early_ready();
    int lat;
    @(negedge clk);
    in_s = 1'b0; in_e = 8'd127; in_m = 28'h4000000; rmode = 2'b00; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    total++; if (lat !== 3) begin bad++; $display("FAIL early_ready_lat got=%0d exp=3", lat); end
    total++; if (Y !== 32'h3F800000) begin bad++; $display("FAIL early_ready_y got=%h exp=3f800000", Y); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL early_ready_drop got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid_norm();
    logic [31:0] y; logic ovf, inx; int lat;
    @(negedge clk);
    in_s = 1'b0; in_e = 8'd130; in_m = 28'h0800000; rmode = 2'b00; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL busy_in_ready got=%b exp=0", in_ready); end
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || Y !== 32'h0) begin
      bad++; $display("FAIL mid_reset ov=%b ir=%b y=%h exp=0/1/00000000", out_valid, in_ready, Y);
    end
    @(negedge clk); rst = 1'b0;
    do_op(1'b0, 8'd127, 28'h8000000, 2'b00, y, ovf, inx, lat);
    total++; if (y !== 32'h40000000 || lat !== 3) begin
      bad++; $display("FAIL after_reset y=%h lat=%0d exp=40000000/3", y, lat);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_s = 1'b0; in_e = 8'd0; in_m = 28'd0; rmode = 2'b00;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_normalize();
    test_rounding();
    test_overflow();
    test_subnormal_zero();
    test_backpressure();
    test_early_ready();
    test_reset_mid_norm();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
